// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and constants for the SAR ADC sequencer.
//   seq_state_t  - sequencer state encoding
//   *LenW        - widths of the programmable phase-length fields
//   GapMax       - largest supported inter-phase gap
//   len_load     - timer reload value for a phase of max(len,1) cycles
//   phase_load   - reload value for the phase about to be entered
package adc_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StSamp,
      StComp,
      StUpdate,
      StGap,
      StDone
   } seq_state_t;

   localparam int unsigned InitLenW   = 4;
   localparam int unsigned SampLenW   = 8;
   localparam int unsigned CompLenW   = 4;
   localparam int unsigned UpdateLenW = 4;
   localparam int unsigned GapMax     = 3;
   localparam int unsigned TimerW     = 8;

   // The timer counts down to zero inclusive, so a phase of L cycles loads L-1.
   // A programmed length of 0 behaves as 1.
   function automatic logic [TimerW-1:0] len_load(input logic [TimerW-1:0] len);
      return (len == '0) ? '0 : len - TimerW'(1);
   endfunction

   function automatic logic [TimerW-1:0] phase_load(
      input seq_state_t             ph,
      input logic [SampLenW-1:0]    samp_len,
      input logic [CompLenW-1:0]    comp_len,
      input logic [UpdateLenW-1:0]  update_len
   );
      logic [TimerW-1:0] len;
      case (ph)
         StSamp:   len = TimerW'(samp_len);
         StComp:   len = TimerW'(comp_len);
         StUpdate: len = TimerW'(update_len);
         default:  len = '0;
      endcase
      return len_load(len);
   endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// seq_phase_timer: loadable down-counter shared by every phase and gap.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_i      - reload the counter with load_val_i (wins over counting)
//   load_val_i  - cycles remaining minus one
//   done_o      - counter is at zero: current cycle is the last of the phase
module seq_phase_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/adc_sequencer.sv
// adc_sequencer: SAR conversion timing generator.
//   start / cont_mode      - single-shot request / automatic restart after DONE
//   cfg_*_len, cfg_ncycles - phase lengths and compare/update pair count, latched at start
//   comp_out               - comparator decision, captured at the end of each compare phase
//   seq_init/samp/comp/update, busy - registered strobes and activity flag
//   result, result_valid   - last conversion (first decision in bit N-1) and its update pulse
module adc_sequencer
   import adc_seq_pkg::*;
#(
   parameter int unsigned MAX_CYCLES = 16,
   parameter int unsigned GAP        = 1,
   parameter int unsigned NCW        = $clog2(MAX_CYCLES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  cont_mode,
   input  logic [InitLenW-1:0]   cfg_init_len,
   input  logic [SampLenW-1:0]   cfg_samp_len,
   input  logic [CompLenW-1:0]   cfg_comp_len,
   input  logic [UpdateLenW-1:0] cfg_update_len,
   input  logic [NCW-1:0]        cfg_ncycles,
   input  logic                  comp_out,
   output logic                  seq_init,
   output logic                  seq_samp,
   output logic                  seq_comp,
   output logic                  seq_update,
   output logic                  busy,
   output logic [MAX_CYCLES-1:0] result,
   output logic                  result_valid
);

   // Out-of-range gaps saturate at the largest supported value.
   localparam int unsigned GapEff = (GAP > GapMax) ? GapMax : GAP;
   localparam logic [TimerW-1:0] GapLoad = (GapEff == 0) ? '0 : TimerW'(GapEff - 1);

   seq_state_t state_d, state_q, next_d, next_q, adv_to;
   logic adv, start_conv;
   logic [SampLenW-1:0]   samp_len_d, samp_len_q;
   logic [CompLenW-1:0]   comp_len_d, comp_len_q;
   logic [UpdateLenW-1:0] update_len_d, update_len_q;
   logic [NCW-1:0]        pairs_d, pairs_q, n_eff;
   logic [MAX_CYCLES-1:0] shreg_d, shreg_q, result_d, result_q;
   logic seq_init_d, seq_init_q, seq_samp_d, seq_samp_q;
   logic seq_comp_d, seq_comp_q, seq_update_d, seq_update_q;
   logic busy_d, busy_q, result_valid_d, result_valid_q;
   logic tmr_load, tmr_done;
   logic [TimerW-1:0] tmr_val;

   seq_phase_timer #(
      .W (TimerW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   always_comb begin
      if (cfg_ncycles == '0) begin
         n_eff = NCW'(1);
      end else if (cfg_ncycles > NCW'(MAX_CYCLES)) begin
         n_eff = NCW'(MAX_CYCLES);
      end else begin
         n_eff = cfg_ncycles;
      end
   end

   always_comb begin
      state_d      = state_q;
      next_d       = next_q;
      samp_len_d   = samp_len_q;
      comp_len_d   = comp_len_q;
      update_len_d = update_len_q;
      pairs_d      = pairs_q;
      shreg_d      = shreg_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      adv          = 1'b0;
      adv_to       = StIdle;
      start_conv   = 1'b0;

      case (state_q)
         StIdle: start_conv = start;
         StInit: begin
            if (tmr_done) begin
               adv    = 1'b1;
               adv_to = StSamp;
            end
         end
         StSamp: begin
            if (tmr_done) begin
               adv    = 1'b1;
               adv_to = StComp;
            end
         end
         StComp: begin
            if (tmr_done) begin
               shreg_d = {shreg_q[MAX_CYCLES-2:0], comp_out};
               adv     = 1'b1;
               adv_to  = StUpdate;
            end
         end
         StUpdate: begin
            if (tmr_done) begin
               adv = 1'b1;
               if (pairs_q == NCW'(1)) begin
                  adv_to = StDone;
               end else begin
                  pairs_d = pairs_q - NCW'(1);
                  adv_to  = StComp;
               end
            end
         end
         StGap: begin
            if (tmr_done) begin
               state_d  = next_q;
               tmr_load = 1'b1;
               tmr_val  = phase_load(next_q, samp_len_q, comp_len_q, update_len_q);
            end
         end
         // DONE doubles as the gap before an automatic restart.
         StDone: begin
            if (cont_mode) begin
               start_conv = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Automatic restarts re-latch the configuration just like a fresh start.
      // The init length goes straight into the timer, so it needs no holding flop.
      if (start_conv) begin
         state_d      = StInit;
         samp_len_d   = cfg_samp_len;
         comp_len_d   = cfg_comp_len;
         update_len_d = cfg_update_len;
         pairs_d      = n_eff;
         shreg_d      = '0;
         tmr_load     = 1'b1;
         tmr_val      = len_load(TimerW'(cfg_init_len));
      end

      if (adv) begin
         tmr_load = 1'b1;
         if (GapEff == 0) begin
            state_d = adv_to;
            tmr_val = phase_load(adv_to, samp_len_q, comp_len_q, update_len_q);
         end else begin
            state_d = StGap;
            next_d  = adv_to;
            tmr_val = GapLoad;
         end
      end

      // Outputs are registered copies of the upcoming state so they stay glitch-free.
      seq_init_d     = (state_d == StInit);
      seq_samp_d     = (state_d == StSamp);
      seq_comp_d     = (state_d == StComp);
      seq_update_d   = (state_d == StUpdate);
      busy_d         = (state_d != StIdle);
      result_valid_d = (state_d == StDone);
      result_d       = (state_d == StDone) ? shreg_q : result_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         next_q         <= StIdle;
         samp_len_q     <= '0;
         comp_len_q     <= '0;
         update_len_q   <= '0;
         pairs_q        <= '0;
         shreg_q        <= '0;
         result_q       <= '0;
         seq_init_q     <= 1'b0;
         seq_samp_q     <= 1'b0;
         seq_comp_q     <= 1'b0;
         seq_update_q   <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         next_q         <= next_d;
         samp_len_q     <= samp_len_d;
         comp_len_q     <= comp_len_d;
         update_len_q   <= update_len_d;
         pairs_q        <= pairs_d;
         shreg_q        <= shreg_d;
         result_q       <= result_d;
         seq_init_q     <= seq_init_d;
         seq_samp_q     <= seq_samp_d;
         seq_comp_q     <= seq_comp_d;
         seq_update_q   <= seq_update_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign seq_init     = seq_init_q;
   assign seq_samp     = seq_samp_q;
   assign seq_comp     = seq_comp_q;
   assign seq_update   = seq_update_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;

endmodule
